// File: rtl/ocsim_data_sink_pkg.sv
// ocsim_data_sink_pkg: shared check-mode encoding and checksum helpers for the stream sink.
// fold32 XORs every 32-bit chunk of a payload that the caller zero-extends to FoldMax bits;
// a partial top chunk therefore reads as zero-padded.
package ocsim_data_sink_pkg;
  typedef enum logic [1:0] {
    CheckNone  = 2'd0,
    CheckZero  = 2'd1,
    CheckOne   = 2'd2,
    CheckQueue = 2'd3
  } checkMode_e;
  localparam int FoldMax = 512;
  function automatic logic [31:0] fold32(input logic [FoldMax-1:0] data);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < FoldMax / 32; i++) acc ^= data[i*32 +: 32];
    return acc;
  endfunction
  function automatic logic [31:0] rotl1(input logic [31:0] v);
    return {v[30:0], v[31]};
  endfunction
endpackage

// File: rtl/ocsim_data_sink_if.sv
// ocsim_data_sink_if: valid/ready stream bundle.
// master drives inData/inValid and samples inReady; slave is the consuming side.
interface ocsim_data_sink_if #(
  parameter int DataWidth = 32
) ();
  logic [DataWidth-1:0] inData;
  logic                 inValid;
  logic                 inReady;
  modport master (output inData, output inValid, input inReady);
  modport slave (input inData, input inValid, output inReady);
endinterface

// File: rtl/ocsim_data_sink_watchdog.sv
// ocsim_data_sink_watchdog: stall detector for stream endpoints.
// Ports: clock, reset (async, active-high), running (counting enabled), activity (a transfer
// happened this edge), stalled (sticky flag, cleared by the next activity). Timeout 0 disables it.
module ocsim_data_sink_watchdog #(
  parameter int Timeout = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic running,
  input  logic activity,
  output logic stalled
);
  localparam int CntW = Timeout > 0 ? $clog2(Timeout + 1) : 1;
  logic [CntW-1:0] idleCount;
  logic atLimit, hitNow;
  assign atLimit = idleCount == CntW'(Timeout);
  // stalled rises on the same edge the counter lands on Timeout
  assign hitNow = Timeout != 0 && running && !activity && idleCount == CntW'(Timeout - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      idleCount <= '0;
      stalled   <= 1'b0;
    end else begin
      idleCount <= (!running || activity) ? '0 : atLimit ? idleCount : idleCount + 1'b1;
      stalled   <= activity ? 1'b0 : hitNow ? 1'b1 : stalled;
    end
endmodule

// File: rtl/ocsim_data_sink.sv
// ocsim_data_sink: randomly throttled stream consumer with data, protocol and stall checking.
// Ports: clock, reset (async, active-high); bus (slave side of the stream);
// running/dutyCycle(0..100)/checkMode configuration, left untouched by reset;
// pushValid/pushData load the expect queue, pushDropped pulses when a push hits a full queue;
// queueLevel/queueEmpty report the queue; count, checksum, errorCount (saturating), stalled.
module ocsim_data_sink
  import ocsim_data_sink_pkg::*;
#(
  parameter int          DataWidth    = 32,
  parameter int          ExpectDepth  = 64,
  parameter int          StallTimeout = 1000,
  parameter logic [31:0] Seed         = 32'h1357_9BDF,
  localparam int         LevelW       = $clog2(ExpectDepth + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  ocsim_data_sink_if.slave     bus,
  input  logic                 running,
  input  logic [6:0]           dutyCycle,
  input  checkMode_e           checkMode,
  input  logic                 pushValid,
  input  logic [DataWidth-1:0] pushData,
  output logic                 pushDropped,
  output logic [LevelW-1:0]    queueLevel,
  output logic                 queueEmpty,
  output logic [31:0]          count,
  output logic [31:0]          checksum,
  output logic [31:0]          errorCount,
  output logic                 stalled
);
  localparam int PtrW = ExpectDepth > 1 ? $clog2(ExpectDepth) : 1;
  logic [DataWidth-1:0] expectMem [ExpectDepth];
  logic [DataWidth-1:0] heldData, expected;
  logic [PtrW-1:0] rdPtr, wrPtr;
  logic [31:0] lfsr, lfsrA, lfsrB, lfsrNext, pctProd;
  logic [32:0] errSum;
  logic [1:0] errInc;
  logic randHit, transfer, queueFull, doPush, doPop, mismatch, protoErr, holdPending;
  function automatic logic [PtrW-1:0] bump(input logic [PtrW-1:0] p);
    return p == PtrW'(ExpectDepth - 1) ? '0 : p + 1'b1;
  endfunction
  // xorshift32; the low half scaled by 100 gives a uniform 0..99 percentile
  assign lfsrA    = lfsr ^ (lfsr << 13);
  assign lfsrB    = lfsrA ^ (lfsrA >> 17);
  assign lfsrNext = lfsrB ^ (lfsrB << 5);
  assign pctProd  = {16'd0, lfsr[15:0]} * 32'd100;
  assign randHit  = {25'd0, dutyCycle} > (pctProd >> 16);
  assign transfer   = bus.inValid && bus.inReady;
  assign queueEmpty = queueLevel == '0;
  assign queueFull  = queueLevel == LevelW'(ExpectDepth);
  assign expected   = expectMem[rdPtr];
  assign doPop      = transfer && checkMode == CheckQueue && !queueEmpty;
  // a pop on the same edge frees the slot a push needs
  assign doPush     = pushValid && (!queueFull || doPop);
  always_comb begin
    mismatch = 1'b0;
    if (transfer)
      mismatch = checkMode == CheckZero  ? bus.inData != '0 :
                 checkMode == CheckOne   ? bus.inData != '1 :
                 checkMode == CheckQueue ? (queueEmpty || bus.inData != expected) : 1'b0;
  end
  // a beat offered but refused last edge must be re-offered unchanged
  assign protoErr = holdPending && (!bus.inValid || bus.inData != heldData);
  assign errInc   = {1'b0, mismatch} + {1'b0, protoErr};
  assign errSum   = {1'b0, errorCount} + {31'd0, errInc};
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      lfsr        <= Seed;
      bus.inReady <= 1'b0;
      holdPending <= 1'b0;
      heldData    <= '0;
      count       <= '0;
      checksum    <= '0;
      errorCount  <= '0;
      rdPtr       <= '0;
      wrPtr       <= '0;
      queueLevel  <= '0;
      pushDropped <= 1'b0;
    end else begin
      lfsr        <= lfsrNext;
      bus.inReady <= running && randHit;
      holdPending <= bus.inValid && !bus.inReady;
      heldData    <= bus.inData;
      count       <= transfer ? count + 32'd1 : count;
      checksum    <= transfer ? rotl1(checksum) ^ fold32(FoldMax'(bus.inData)) : checksum;
      errorCount  <= errSum[32] ? '1 : errSum[31:0];
      rdPtr       <= doPop ? bump(rdPtr) : rdPtr;
      wrPtr       <= doPush ? bump(wrPtr) : wrPtr;
      queueLevel  <= queueLevel + LevelW'(doPush) - LevelW'(doPop);
      pushDropped <= pushValid && !doPush;
    end
  always_ff @(posedge clock)
    if (doPush) expectMem[wrPtr] <= pushData;
  ocsim_data_sink_watchdog #(.Timeout(StallTimeout)) watchdog (
    .clock    (clock),
    .reset    (reset),
    .running  (running),
    .activity (transfer),
    .stalled  (stalled)
  );
endmodule

// File: tb/tb_ocsim_data_sink.sv
// tb_ocsim_data_sink: randomized bench for ocsim_data_sink against a queue-based reference model.
module tb_ocsim_data_sink;
  import ocsim_data_sink_pkg::*;
  localparam int DW = 32;
  localparam int Depth = 64;
  localparam int Timeout = 20;
  logic clock = 1'b0;
  logic reset, running, pushValid, pushDropped, queueEmpty, stalled;
  logic [6:0] dutyCycle, queueLevel;
  checkMode_e checkMode;
  logic [DW-1:0] pushData;
  logic [31:0] count, checksum, errorCount;
  ocsim_data_sink_if #(.DataWidth(DW)) bus ();
  ocsim_data_sink #(.DataWidth(DW), .ExpectDepth(Depth), .StallTimeout(Timeout)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .running     (running),
    .dutyCycle   (dutyCycle),
    .checkMode   (checkMode),
    .pushValid   (pushValid),
    .pushData    (pushData),
    .pushDropped (pushDropped),
    .queueLevel  (queueLevel),
    .queueEmpty  (queueEmpty),
    .count       (count),
    .checksum    (checksum),
    .errorCount  (errorCount),
    .stalled     (stalled)
  );
  always #5 clock = ~clock;
  int unsigned nCompared = 0, nMismatched = 0;
  logic [31:0] sendQ[$], expQ[$];
  logic [31:0] mCount, mChecksum, mHeldData;
  longint mErrors;
  int mIdle, srcDuty;
  bit mStalled, mHold, mDropped, accepted, readyKnown, readyWant, glitchData, dropValid, freeRun;
  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] want);
    nCompared++;
    if (got !== want) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask
  function automatic logic [31:0] foldRef(input logic [DW-1:0] d);
    logic [31:0] acc = 0;
    for (int i = 0; i < DW; i += 32) acc ^= 32'(d >> i);
    return acc;
  endfunction
  function automatic logic [31:0] randData();
    int r = $urandom_range(3);
    return r == 0 ? 32'd0 : r == 1 ? 32'hFFFF_FFFF : 32'($urandom());
  endfunction
  task automatic cycle();
    bit xfer, mis, proto;
    logic [31:0] front;
    @(negedge clock);
    if (!bus.inValid || accepted) begin
      bus.inValid = 1'b0;
      if ((sendQ.size() > 0 || freeRun) && $urandom_range(99) < srcDuty) begin
        bus.inValid = 1'b1;
        bus.inData = sendQ.size() > 0 ? sendQ.pop_front() : randData();
      end
    end
    if (glitchData) bus.inData = ~bus.inData;
    if (dropValid) bus.inValid = 1'b0;
    glitchData = 0;
    dropValid = 0;
    if (reset) begin
      expQ.delete();
      mCount = 0; mChecksum = 0; mErrors = 0; mIdle = 0; mStalled = 0;
      mHold = 0; mHeldData = 0; mDropped = 0; accepted = 0;
      readyKnown = 1; readyWant = 0;
    end else begin
      xfer = bus.inValid && bus.inReady;
      proto = mHold && (!bus.inValid || bus.inData != mHeldData);
      mis = 0;
      if (xfer) begin
        if (checkMode == CheckZero) mis = bus.inData != 32'd0;
        else if (checkMode == CheckOne) mis = bus.inData != 32'hFFFF_FFFF;
        else if (checkMode == CheckQueue) begin
          if (expQ.size() == 0) mis = 1;
          else begin
            front = expQ.pop_front();
            mis = front != bus.inData;
          end
        end
        mCount = mCount + 1;
        mChecksum = ((mChecksum << 1) | (mChecksum >> 31)) ^ foldRef(bus.inData);
      end
      mDropped = 0;
      if (pushValid) begin
        if (expQ.size() < Depth) expQ.push_back(pushData);
        else mDropped = 1;
      end
      mErrors = mErrors + longint'(mis) + longint'(proto);
      if (mErrors > 64'hFFFF_FFFF) mErrors = 64'hFFFF_FFFF;
      mHold = bus.inValid && !bus.inReady;
      mHeldData = bus.inData;
      mIdle = (!running || xfer) ? 0 : mIdle + 1;
      if (xfer) mStalled = 0;
      else if (mIdle == Timeout) mStalled = 1;
      accepted = xfer;
      readyKnown = !running || dutyCycle == 0 || dutyCycle >= 100;
      readyWant = running && dutyCycle != 0;
    end
    @(posedge clock);
    #1;
    checkEq("count", count, mCount);
    checkEq("checksum", checksum, mChecksum);
    checkEq("errorCount", errorCount, mErrors);
    checkEq("stalled", stalled, mStalled);
    checkEq("queueLevel", queueLevel, expQ.size());
    checkEq("queueEmpty", queueEmpty, expQ.size() == 0);
    checkEq("pushDropped", pushDropped, mDropped);
    if (readyKnown) checkEq("inReady", bus.inReady, readyWant);
  endtask
  task automatic push(input logic [31:0] v);
    pushValid = 1;
    pushData = v;
    cycle();
    pushValid = 0;
  endtask
  task automatic waitCount(input logic [31:0] target, input int budget, input string tag);
    for (int i = 0; i < budget && mCount != target; i++) cycle();
    checkEq(tag, count, target);
  endtask
  initial begin
    logic [31:0] v;
    reset = 1; running = 0; pushValid = 0; pushData = 0; dutyCycle = 100; checkMode = CheckNone;
    bus.inValid = 0; bus.inData = 0;
    srcDuty = 0; freeRun = 0; accepted = 0; glitchData = 0; dropValid = 0;
    repeat (3) cycle();
    reset = 0;
    cycle();
    checkEq("rstCount", count, 0);
    checkEq("rstErr", errorCount, 0);
    // checksum of 0x1 then 0x2
    running = 1; srcDuty = 100;
    sendQ.push_back(32'h1);
    sendQ.push_back(32'h2);
    waitCount(1, 20, "beat1Count");
    checkEq("cksumBeat1", checksum, 32'h1);
    waitCount(2, 20, "beat2Count");
    checkEq("cksumBeat2", checksum, 32'h0);
    // queue match
    checkMode = CheckQueue; srcDuty = 0;
    repeat (2) cycle();
    for (int i = 0; i < 16; i++) begin
      v = $urandom();
      sendQ.push_back(v);
      push(v);
    end
    checkEq("qLevel16", queueLevel, 16);
    srcDuty = 50; dutyCycle = 30;
    for (int i = 0; i < 2000 && !(queueEmpty && sendQ.size() == 0); i++) cycle();
    checkEq("waitIdle", queueEmpty, 1);
    checkEq("sendDrained", sendQ.size(), 0);
    checkEq("qMatchErr", errorCount, 0);
    // queue mismatch and underflow
    push(32'hA5);
    sendQ.push_back(32'h5A);
    waitCount(19, 500, "mmCount");
    checkEq("mismatchErr", errorCount, 1);
    sendQ.push_back(32'h77);
    waitCount(20, 500, "ufCount");
    checkEq("underflowErr", errorCount, 2);
    // overflow
    srcDuty = 0;
    repeat (3) cycle();
    for (int i = 0; i < 65; i++) push($urandom());
    checkEq("ovfDrop", pushDropped, 1);
    checkEq("ovfLevel", queueLevel, 64);
    checkEq("ovfErr", errorCount, 2);
    // reset mid-stream
    checkMode = CheckNone; freeRun = 1; srcDuty = 100; dutyCycle = 100;
    repeat (5) cycle();
    reset = 1;
    repeat (3) begin
      cycle();
      checkEq("rstMidCount", count, 0);
      checkEq("rstMidLevel", queueLevel, 0);
      checkEq("rstMidReady", bus.inReady, 0);
    end
    reset = 0;
    waitCount(1, 10, "firstAfterRst");
    // protocol violations
    freeRun = 0;
    repeat (3) cycle();
    dutyCycle = 0;
    repeat (2) cycle();
    sendQ.push_back(32'h1234);
    cycle();
    glitchData = 1;
    cycle();
    checkEq("protoData", errorCount, 1);
    cycle();
    dropValid = 1;
    cycle();
    checkEq("protoDrop", errorCount, 2);
    // stall watchdog
    dutyCycle = 100;
    sendQ.push_back(32'h9);
    waitCount(mCount + 1, 20, "stallPrimeCount");
    checkEq("stallPrime", stalled, 0);
    srcDuty = 0;
    repeat (19) cycle();
    checkEq("stall19", stalled, 0);
    cycle();
    checkEq("stall20", stalled, 1);
    srcDuty = 100;
    sendQ.push_back(32'h5);
    waitCount(mCount + 1, 20, "stallBeatCount");
    checkEq("stallCleared", stalled, 0);
    // randomized soak
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(15) == 0) dutyCycle = 7'($urandom_range(100));
      if ($urandom_range(15) == 0) srcDuty = $urandom_range(100);
      if ($urandom_range(31) == 0) checkMode = checkMode_e'($urandom_range(3));
      if ($urandom_range(47) == 0) running = !running;
      freeRun = $urandom_range(1);
      glitchData = $urandom_range(39) == 0;
      dropValid = $urandom_range(39) == 0;
      pushValid = $urandom_range(2) == 0;
      pushData = $urandom();
      if (pushValid && sendQ.size() < 8) sendQ.push_back(pushData);
      if ($urandom_range(199) == 0) reset = 1;
      cycle();
      pushValid = 0;
      reset = 0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
